systolic_seq_ctrl: RTL and testbench

Sequencer for an N×N output-stationary systolic array of 8-bit PEs.
- On `start`, it clears the array and streams k_len operand vectors from the A (row) and B (column) operand buffers into the array edges, skewing lane i by i cycles.
- It then waits for the wavefront to drain and steps the result-row mux so the result buffer captures N rows.
- It sits between the operand/result buffers and the PE grid and is the only block that drives array control.

---
 rtl/systolic_seq_ctrl_if.sv | 38 +++
 rtl/systolic_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_if.sv
// Purpose : bundles the sequencer's launch, operand-read, array-feed and result-write signals.
// Latency : none; this interface only carries wires.
// Backpressure: none; operand reads and result writes are strobed, with no ready signal.
// Ports   : master = sequencer side (drives strobes, feeds, status); slave = buffers/array/launcher.
interface systolic_seq_ctrl_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int K_W    = 8
);
    logic                   start;
    logic [K_W-1:0]         k_len;
    logic                   busy;
    logic                   done;
    logic                   a_rd_en;
    logic                   b_rd_en;
    logic [ADDR_W-1:0]      a_rd_addr;
    logic [ADDR_W-1:0]      b_rd_addr;
    logic [N*DATA_W-1:0]    a_rd_data;
    logic [N*DATA_W-1:0]    b_rd_data;
    logic [N*DATA_W-1:0]    row_feed;
    logic [N*DATA_W-1:0]    col_feed;
    logic                   arr_clear;
    logic                   res_we;
    logic [$clog2(N)-1:0]   res_row;

    modport master (
        input  start, k_len, a_rd_data, b_rd_data,
        output busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
               row_feed, col_feed, arr_clear, res_we, res_row
    );

    modport slave (
        output start, k_len, a_rd_data, b_rd_data,
        input  busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
               row_feed, col_feed, arr_clear, res_we, res_row
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Purpose : sequences an NxN output-stationary systolic array: clear, skewed operand feed, drain, row writeback.
// Latency : a run of k_len vectors lasts k_len+4N+2 cycles from the accepted start to the done pulse (1 cycle if k_len=0).
// Backpressure: none; start is only sampled in IDLE, and a start while busy is dropped, not queued.
// Ports   : clk, rst_n (async active-low) are plain ports; everything else travels on bus (systolic_seq_ctrl_if.master).
//           Optional macro SYSCTRL_ABORT_EN adds an 'abort' input that forces the run to DONE.
module systolic_seq_ctrl #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int K_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef SYSCTRL_ABORT_EN
    input  logic                abort,
`endif
    systolic_seq_ctrl_if.master bus
);
    localparam int RW    = $clog2(N);
    localparam int FL_W  = $clog2(3 * N);
    // One counter serves as the fetch address, the flush count and the write row.
    localparam int CNT_W = (K_W > FL_W) ? K_W : FL_W;
    localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(3 * N - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_FLUSH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [K_W-1:0]     klen_q, klen_d;
    logic               pipe_clr;
    logic               abort_hit;
    logic               vld_q;

    logic [N*DATA_W-1:0] row_w;
    logic [N*DATA_W-1:0] col_w;

`ifdef SYSCTRL_ABORT_EN
    assign abort_hit = abort && (state_q inside {S_CLEAR, S_FETCH, S_FLUSH, S_WRITE});
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            klen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            klen_q  <= klen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        klen_d   = klen_q;
        pipe_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    klen_d  = bus.k_len;
                    cnt_d   = '0;
                    // A zero-length product has nothing to clear, fetch or write.
                    state_d = (bus.k_len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // klen_q is nonzero here, so klen_q-1 cannot underflow.
                if (cnt_q == CNT_W'(klen_q - K_W'(1))) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                // 3N cycles covers the N-cycle skew plus the 2N-cycle wavefront across the grid.
                if (cnt_q == FL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            pipe_clr = 1'b1;
        end
    end

    // Buffer data lands the cycle after the read strobe; this flag marks those cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (pipe_clr) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= (state_q == S_FETCH);
        end
    end

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            logic [DATA_W-1:0] a_in;
            logic [DATA_W-1:0] b_in;
            // Bubbles enter the array as zeros so they add nothing to the accumulators.
            assign a_in = vld_q ? bus.a_rd_data[i*DATA_W +: DATA_W] : '0;
            assign b_in = vld_q ? bus.b_rd_data[i*DATA_W +: DATA_W] : '0;

            if (i == 0) begin : g_direct
                // Lane 0 is unskewed: buffer output passes through the valid gate only.
                assign row_w[DATA_W-1:0] = a_in;
                assign col_w[DATA_W-1:0] = b_in;
            end else begin : g_skew
                logic [DATA_W-1:0] a_sr [i];
                logic [DATA_W-1:0] b_sr [i];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int j = 0; j < i; j++) begin
                            a_sr[j] <= '0;
                            b_sr[j] <= '0;
                        end
                    end else if (pipe_clr) begin
                        for (int j = 0; j < i; j++) begin
                            a_sr[j] <= '0;
                            b_sr[j] <= '0;
                        end
                    end else begin
                        a_sr[0] <= a_in;
                        b_sr[0] <= b_in;
                        for (int j = 1; j < i; j++) begin
                            a_sr[j] <= a_sr[j-1];
                            b_sr[j] <= b_sr[j-1];
                        end
                    end
                end

                assign row_w[i*DATA_W +: DATA_W] = a_sr[i-1];
                assign col_w[i*DATA_W +: DATA_W] = b_sr[i-1];
            end
        end
    endgenerate

    // Control outputs decode the state register only; no input reaches them combinationally.
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.arr_clear = (state_q == S_CLEAR);
    assign bus.a_rd_en   = (state_q == S_FETCH);
    assign bus.b_rd_en   = (state_q == S_FETCH);
    assign bus.a_rd_addr = (state_q == S_FETCH) ? ADDR_W'(cnt_q) : '0;
    assign bus.b_rd_addr = (state_q == S_FETCH) ? ADDR_W'(cnt_q) : '0;
    assign bus.res_we    = (state_q == S_WRITE);
    assign bus.res_row   = (state_q == S_WRITE) ? cnt_q[RW-1:0] : '0;
    assign bus.row_feed  = row_w;
    assign bus.col_feed  = col_w;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int KW = 8;
    localparam int CW = 6 + 2 + 2 * AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
`ifdef SYSCTRL_ABORT_EN
    logic abort = 1'b0;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    systolic_seq_ctrl_if #(.N(N), .DATA_W(DW), .ADDR_W(AW), .K_W(KW)) bif ();

    systolic_seq_ctrl #(.N(N), .DATA_W(DW), .ADDR_W(AW), .K_W(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SYSCTRL_ABORT_EN
        .abort (abort),
`endif
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Operand buffers: A lanes hold addr+1, B lanes hold 2; junk when not read.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            bif.a_rd_data[i*DW +: DW] <= bif.a_rd_en ? 8'(bif.a_rd_addr + 10'd1) : 8'hEE;
            bif.b_rd_data[i*DW +: DW] <= bif.b_rd_en ? 8'd2 : 8'hEE;
        end
    end

    logic [CW-1:0] ctrl_now;
    assign ctrl_now = {bif.busy, bif.done, bif.arr_clear, bif.a_rd_en, bif.b_rd_en,
                       bif.res_we, bif.res_row, bif.a_rd_addr, bif.b_rd_addr};

    // Expected control word for cycle c after a start with length k.
    function automatic logic [CW-1:0] exp_ctrl(input int k, input int c);
        logic busy, done, clr, en, we;
        logic [1:0]    row;
        logic [AW-1:0] addr;
        busy = 1'b0; done = 1'b0; clr = 1'b0; en = 1'b0; we = 1'b0;
        row  = '0;   addr = '0;
        if (k == 0) begin
            busy = (c == 1);
            done = (c == 1);
        end else begin
            busy = (c >= 1) && (c <= k + 4*N + 2);
            clr  = (c == 1);
            en   = (c >= 2) && (c <= k + 1);
            if (en) addr = AW'(c - 2);
            we   = (c >= k + 3*N + 2) && (c <= k + 4*N + 1);
            if (we) row = 2'(c - (k + 3*N + 2));
            done = (c == k + 4*N + 2);
        end
        return {busy, done, clr, en, en, we, row, addr, addr};
    endfunction

    // Expected edge feed: lane i carries address (c-3-i) while that address is in range.
    function automatic logic [N*DW-1:0] exp_feed(input int k, input int c, input bit is_a);
        logic [N*DW-1:0] v;
        int a;
        v = '0;
        for (int i = 0; i < N; i++) begin
            a = c - 3 - i;
            if (a >= 0 && a < k) v[i*DW +: DW] = is_a ? 8'(a + 1) : 8'd2;
        end
        return v;
    endfunction

    task automatic launch(input int k);
        bif.k_len = KW'(k);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ctrl_now, bif.row_feed, bif.col_feed} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold got ctrl=%h row=%h col=%h want all 0", ctrl_now, bif.row_feed, bif.col_feed);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== '0) begin
                n_bad++;
                $display("FAIL idle_ctrl c=%0d got=%h want=0", c, ctrl_now);
            end
            n_cmp++;
            if ({bif.row_feed, bif.col_feed} !== '0) begin
                n_bad++;
                $display("FAIL idle_feed c=%0d got row=%h col=%h want 0", c, bif.row_feed, bif.col_feed);
            end
        end
    endtask

    task automatic test_single_run();
        launch(4);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== exp_ctrl(4, c)) begin
                n_bad++;
                $display("FAIL run4_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(4, c));
            end
            n_cmp++;
            if (bif.row_feed !== exp_feed(4, c, 1'b1)) begin
                n_bad++;
                $display("FAIL run4_row c=%0d got=%h want=%h", c, bif.row_feed, exp_feed(4, c, 1'b1));
            end
            n_cmp++;
            if (bif.col_feed !== exp_feed(4, c, 1'b0)) begin
                n_bad++;
                $display("FAIL run4_col c=%0d got=%h want=%h", c, bif.col_feed, exp_feed(4, c, 1'b0));
            end
            if (c == 6) begin
                n_cmp++;
                if (bif.row_feed[3*DW +: DW] !== 8'd1) begin
                    n_bad++;
                    $display("FAIL run4_lane3_c6 got=%h want=01", bif.row_feed[3*DW +: DW]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        launch(0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== exp_ctrl(0, c)) begin
                n_bad++;
                $display("FAIL k0_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(0, c));
            end
            n_cmp++;
            if ({bif.row_feed, bif.col_feed} !== '0) begin
                n_bad++;
                $display("FAIL k0_feed c=%0d got row=%h col=%h want 0", c, bif.row_feed, bif.col_feed);
            end
        end
    endtask

    task automatic test_ignored_start();
        int dones;
        dones = 0;
        launch(3);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (bif.done === 1'b1) dones++;
            n_cmp++;
            if (ctrl_now !== exp_ctrl(3, c)) begin
                n_bad++;
                $display("FAIL ign_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(3, c));
            end
            n_cmp++;
            if (bif.row_feed !== exp_feed(3, c, 1'b1)) begin
                n_bad++;
                $display("FAIL ign_row c=%0d got=%h want=%h", c, bif.row_feed, exp_feed(3, c, 1'b1));
            end
            if (c == 3)  begin bif.start = 1'b1; bif.k_len = '0; end
            if (c == 4)  bif.start = 1'b0;
            if (c == 21) bif.start = 1'b1;
            if (c == 22) bif.start = 1'b0;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL ign_done_count got=%0d want=1", dones);
        end
    endtask

    task automatic test_back_to_back();
        launch(2);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== exp_ctrl(2, c)) begin
                n_bad++;
                $display("FAIL b2b_first_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(2, c));
            end
        end
        // First IDLE cycle after DONE: the new start is accepted at the next edge.
        launch(1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== exp_ctrl(1, c)) begin
                n_bad++;
                $display("FAIL b2b_second_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(1, c));
            end
            n_cmp++;
            if ({bif.row_feed, bif.col_feed} !== {exp_feed(1, c, 1'b1), exp_feed(1, c, 1'b0)}) begin
                n_bad++;
                $display("FAIL b2b_second_feed c=%0d got row=%h col=%h want row=%h col=%h", c,
                         bif.row_feed, bif.col_feed, exp_feed(1, c, 1'b1), exp_feed(1, c, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid();
        launch(16);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== exp_ctrl(16, c)) begin
                n_bad++;
                $display("FAIL rmid_pre_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(16, c));
            end
        end
        n_cmp++;
        if (bif.row_feed !== exp_feed(16, 8, 1'b1)) begin
            n_bad++;
            $display("FAIL rmid_pre_row got=%h want=%h", bif.row_feed, exp_feed(16, 8, 1'b1));
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ctrl_now, bif.row_feed, bif.col_feed} !== '0) begin
            n_bad++;
            $display("FAIL rmid_async got ctrl=%h row=%h col=%h want all 0", ctrl_now, bif.row_feed, bif.col_feed);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        launch(2);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== exp_ctrl(2, c)) begin
                n_bad++;
                $display("FAIL rmid_post_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(2, c));
            end
            n_cmp++;
            if (bif.col_feed !== exp_feed(2, c, 1'b0)) begin
                n_bad++;
                $display("FAIL rmid_post_col c=%0d got=%h want=%h", c, bif.col_feed, exp_feed(2, c, 1'b0));
            end
        end
    endtask

`ifdef SYSCTRL_ABORT_EN
    task automatic test_abort();
        launch(8);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_now !== exp_ctrl(8, c)) begin
                n_bad++;
                $display("FAIL abort_pre_ctrl c=%0d got=%h want=%h", c, ctrl_now, exp_ctrl(8, c));
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (ctrl_now !== {2'b11, 26'd0}) begin
            n_bad++;
            $display("FAIL abort_done_ctrl got=%h want=%h", ctrl_now, {2'b11, 26'd0});
        end
        n_cmp++;
        if ({bif.row_feed, bif.col_feed} !== '0) begin
            n_bad++;
            $display("FAIL abort_feed got row=%h col=%h want 0", bif.row_feed, bif.col_feed);
        end
        for (int c = 6; c <= 9; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ctrl_now, bif.row_feed, bif.col_feed} !== '0) begin
                n_bad++;
                $display("FAIL abort_after c=%0d got ctrl=%h row=%h col=%h want all 0", c,
                         ctrl_now, bif.row_feed, bif.col_feed);
            end
        end
    endtask
`endif

    initial begin
        bif.start = 1'b0;
        bif.k_len = '0;
        test_reset();
        test_single_run();
        test_zero_len();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SYSCTRL_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
